hoeraa_error_monitor: RTL and testbench



---
 rtl/approx_adder_pkg.sv | 18 +
 rtl/abs_diff.sv | 23 ++
 rtl/hoeraa_error_monitor.sv | 127 ++++++++++++
 tb/tb_hoeraa_error_monitor.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
// Shared definitions for the approximate-adder error monitors.
package approx_adder_pkg;

  // Monitor FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] mon_state_t;

  localparam mon_state_t ST_IDLE  = 2'd0;
  localparam mon_state_t ST_RUN   = 2'd1;
  localparam mon_state_t ST_DRAIN = 2'd2;
  localparam mon_state_t ST_DONE  = 2'd3;

  // Error distance width: an N-bit adder produces an N+1-bit result, so the
  // exact-vs-approximate distance needs N+1 bits as well.
  function automatic int ed_width(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |a - b| of two W-bit values.
module abs_diff #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff
);

  logic [W:0] w_delta;

  // One extra bit holds the borrow so the difference never wraps; a set
  // borrow means b > a and the two's-complement negation recovers b - a.
  always_comb begin
    w_delta = {1'b0, a} - {1'b0, b};
    if (w_delta[W]) begin
      diff = W'(-w_delta);
    end else begin
      diff = w_delta[W-1:0];
    end
  end

endmodule

// File: rtl/hoeraa_error_monitor.sv
// Error-statistics monitor for the HOERAA approximate adder: recomputes the
// exact sum, derives the error distance and accumulates count/sum/max over
// a run of SAMPLES accepted operand pairs.
module hoeraa_error_monitor
  import approx_adder_pkg::*;
#(
  parameter int N       = 16,
  parameter int SAMPLES = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          x,
  input  logic [N-1:0]          y,
  input  logic [N-1:0]          approx_s,
  input  logic                  approx_co,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      err_count,
  output logic [N+CNT_W:0]      ed_sum,
  output logic [N:0]            ed_max
);

  localparam int ED_W  = ed_width(N);
  localparam int SUM_W = N + 1 + CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES);

  // A run length of zero, or one the sample counter cannot reach, is illegal.
  if (SAMPLES < 1 || longint'(SAMPLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_samples
    $error("hoeraa_error_monitor: SAMPLES out of range for CNT_W");
  end

  mon_state_t         r_state;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_cnt;
  logic [ED_W-1:0]    r_stage_ed;
  logic               r_stage_vld;
  logic [CNT_W-1:0]   r_err_count;
  logic [SUM_W-1:0]   r_ed_sum;
  logic [ED_W-1:0]    r_ed_max;

  mon_state_t         w_next_state;
  logic               w_accept;
  logic               w_start_run;
  logic               w_last;
  logic [ED_W-1:0]    w_exact;
  logic [ED_W-1:0]    w_approx;
  logic [ED_W-1:0]    w_ed;

  assign w_exact  = {1'b0, x} + {1'b0, y};
  assign w_approx = {approx_co, approx_s};

  abs_diff #(.W(ED_W)) u_abs_diff (
    .a    (w_exact),
    .b    (w_approx),
    .diff (w_ed)
  );

  assign w_accept    = (r_state == ST_RUN) && r_in_ready && in_valid;
  assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last      = (r_cnt + 1'b1) == LAST_CNT;

  // Next-state logic; start is only honoured when no run is in flight.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_RUN;
      ST_RUN:   if (w_accept && w_last) w_next_state = ST_DRAIN;
      ST_DRAIN: w_next_state = ST_DONE;
      ST_DONE:  if (start) w_next_state = ST_RUN;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM, registered handshake/status flags, sample counter, ED stage and
  // accumulators. Status flags are derived from the next state so they line
  // up with the state register and never see in_valid combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_stage_ed  <= '0;
      r_stage_vld <= 1'b0;
      r_err_count <= '0;
      r_ed_sum    <= '0;
      r_ed_max    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == ST_RUN);
      r_busy      <= (w_next_state == ST_RUN) || (w_next_state == ST_DRAIN);
      r_done      <= (w_next_state == ST_DONE);
      r_stage_vld <= w_accept;
      if (w_accept) begin
        r_stage_ed <= w_ed;
        r_cnt      <= r_cnt + 1'b1;
      end
      if (w_start_run) begin
        r_cnt       <= '0;
        r_err_count <= '0;
        r_ed_sum    <= '0;
        r_ed_max    <= '0;
      end else if (r_stage_vld) begin
        r_ed_sum    <= r_ed_sum + SUM_W'(r_stage_ed);
        r_err_count <= r_err_count + CNT_W'(r_stage_ed != '0);
        if (r_stage_ed > r_ed_max) begin
          r_ed_max <= r_stage_ed;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err_count;
  assign ed_sum    = r_ed_sum;
  assign ed_max    = r_ed_max;

endmodule

// File: tb/tb_hoeraa_error_monitor.sv
// Self-checking bench for hoeraa_error_monitor: table-driven 4-sample runs,
// control corner cases and randomized runs against an arithmetic model.
module tb_hoeraa_error_monitor;

  localparam int N       = 16;
  localparam int SAMPLES = 4;
  localparam int CNT_W   = 16;

  logic                clk;
  logic                rst;
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        x;
  logic [N-1:0]        y;
  logic [N-1:0]        approx_s;
  logic                approx_co;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    err_count;
  logic [N+CNT_W:0]    ed_sum;
  logic [N:0]          ed_max;

  hoeraa_error_monitor #(.N(N), .SAMPLES(SAMPLES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .approx_s  (approx_s),
    .approx_co (approx_co),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .ed_sum    (ed_sum),
    .ed_max    (ed_max)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] s;
    logic        co;
  } sample_t;

  typedef struct packed {
    sample_t     s0;
    sample_t     s1;
    sample_t     s2;
    sample_t     s3;
    logic [15:0] expErr;
    logic [32:0] expSum;
    logic [16:0] expMax;
  } run_vec_t;

  int          nCompared;
  int          nFailed;
  sample_t     cur [4];
  longint      expErr;
  longint      expSum;
  longint      expMax;
  run_vec_t    table_v [3];

  // Records one comparison and reports it if it does not hold.
  task automatic checkOutput(input string name, input longint act, input longint exp);
    nCompared++;
    if (act != exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference error distance straight from the definition |(x+y) - {co,s}|.
  function automatic longint refEd(input sample_t smp);
    longint exact;
    longint appr;
    exact = longint'(smp.x) + longint'(smp.y);
    appr  = longint'(smp.co) * 65536 + longint'(smp.s);
    return (exact > appr) ? exact - appr : appr - exact;
  endfunction

  // Computes expected run statistics for the samples held in cur[].
  task automatic modelRun();
    longint ed;
    expErr = 0;
    expSum = 0;
    expMax = 0;
    for (int k = 0; k < 4; k++) begin
      ed = refEd(cur[k]);
      if (ed != 0) expErr++;
      expSum += ed;
      if (ed > expMax) expMax = ed;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveSample(input sample_t smp);
    x         = smp.x;
    y         = smp.y;
    approx_s  = smp.s;
    approx_co = smp.co;
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, ".err_count"}, longint'(err_count), expErr);
    checkOutput({tag, ".ed_sum"},    longint'(ed_sum),    expSum);
    checkOutput({tag, ".ed_max"},    longint'(ed_max),    expMax);
  endtask

  // Runs the four samples in cur[] from IDLE/DONE with optional random gaps;
  // extraValid keeps in_valid high with a huge-error sample into DRAIN/DONE.
  task automatic applyStimulus(input string tag, input int gapMax, input bit extraValid);
    sample_t junk;
    int      gaps;
    junk = '{x: 16'hFFFF, y: 16'hFFFF, s: 16'h0000, co: 1'b0};
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, ".in_ready_run"}, longint'(in_ready), 1);
    checkOutput({tag, ".busy_run"},     longint'(busy),     1);
    for (int k = 0; k < 4; k++) begin
      gaps = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
      in_valid = 1'b0;
      for (int g = 0; g < gaps; g++) tick();
      driveSample(cur[k]);
      in_valid = 1'b1;
      tick();
    end
    if (extraValid) driveSample(junk);
    else in_valid = 1'b0;
    checkOutput({tag, ".in_ready_drain"}, longint'(in_ready), 0);
    checkOutput({tag, ".done_drain"},     longint'(done),     0);
    checkOutput({tag, ".busy_drain"},     longint'(busy),     1);
    tick();
    checkOutput({tag, ".done"},          longint'(done),     1);
    checkOutput({tag, ".busy_done"},     longint'(busy),     0);
    checkOutput({tag, ".in_ready_done"}, longint'(in_ready), 0);
    if (extraValid) begin
      tick();
      checkOutput({tag, ".done_hold"}, longint'(done), 1);
    end
    in_valid = 1'b0;
    checkStats(tag);
  endtask

  task automatic loadRun(input run_vec_t r);
    cur[0] = r.s0;
    cur[1] = r.s1;
    cur[2] = r.s2;
    cur[3] = r.s3;
    expErr = longint'(r.expErr);
    expSum = longint'(r.expSum);
    expMax = longint'(r.expMax);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, ".in_ready"},  longint'(in_ready),  0);
    checkOutput({tag, ".busy"},      longint'(busy),      0);
    checkOutput({tag, ".done"},      longint'(done),      0);
    checkOutput({tag, ".err_count"}, longint'(err_count), 0);
    checkOutput({tag, ".ed_sum"},    longint'(ed_sum),    0);
    checkOutput({tag, ".ed_max"},    longint'(ed_max),    0);
  endtask

  // Main sequence.
  initial begin
    longint exact;
    longint appr;
    int     mode;
    nCompared = 0;
    nFailed   = 0;
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    approx_s  = '0;
    approx_co = 1'b0;

    // Hand-computed reference runs: {x, y, s, co} per sample, then stats.
    table_v[0] = '{s0: '{16'h0000, 16'h0000, 16'h0003, 1'b0},
                   s1: '{16'h0008, 16'h0008, 16'h0013, 1'b0},
                   s2: '{16'h0003, 16'h0000, 16'h0003, 1'b0},
                   s3: '{16'hFFFF, 16'h0001, 16'hFFFF, 1'b0},
                   expErr: 16'd3, expSum: 33'd7, expMax: 17'd3};
    table_v[1] = '{s0: '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0},
                   s1: '{16'h0001, 16'h0002, 16'h0003, 1'b0},
                   s2: '{16'h0000, 16'h0000, 16'h0000, 1'b0},
                   s3: '{16'h8000, 16'h8000, 16'h0000, 1'b1},
                   expErr: 16'd1, expSum: 33'h1FFFE, expMax: 17'h1FFFE};
    table_v[2] = '{s0: '{16'h0000, 16'h0000, 16'hFFFF, 1'b1},
                   s1: '{16'h1234, 16'h1111, 16'h2345, 1'b0},
                   s2: '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1},
                   s3: '{16'h0010, 16'h0000, 16'h0000, 1'b0},
                   expErr: 16'd2, expSum: 33'h2000F, expMax: 17'h1FFFF};

    tick();
    tick();
    rst = 1'b0;
    tick();
    checkIdleZero("reset");

    // Table runs, back-to-back; each later run restarts from DONE.
    for (int i = 0; i < 3; i++) begin
      loadRun(table_v[i]);
      applyStimulus($sformatf("table%0d", i), 0, 1'b0);
    end

    // Same first run with gaps and a stray in_valid held into DRAIN/DONE.
    loadRun(table_v[0]);
    applyStimulus("gaps", 3, 1'b1);

    // start pulsed mid-RUN must neither restart the run nor clear stats.
    loadRun(table_v[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
      end
      driveSample(cur[k]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("midStart.in_ready_drain", longint'(in_ready), 0);
    tick();
    checkOutput("midStart.done", longint'(done), 1);
    checkStats("midStart");

    // Reset in the middle of a run discards it.
    loadRun(table_v[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      driveSample(cur[k]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checkOutput("midRst.ed_max_pre", longint'(ed_max), 64'h1FFFE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdleZero("midRst");

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkIdleZero("rstStart");

    // Randomized runs checked against the arithmetic model.
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 4; k++) begin
        cur[k].x = 16'($urandom);
        cur[k].y = 16'($urandom);
        exact = longint'(cur[k].x) + longint'(cur[k].y);
        mode  = int'($urandom_range(2, 0));
        if (mode == 0) appr = exact;
        else if (mode == 1) appr = exact + longint'($urandom_range(16, 0)) - 8;
        else appr = longint'($urandom_range(131071, 0));
        appr = appr & 64'h1FFFF;
        cur[k].s  = appr[15:0];
        cur[k].co = appr[16];
      end
      modelRun();
      applyStimulus($sformatf("rand%0d", r), 2, r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
